// File: rtl/sum_stage_if.sv
// Beat/result bus of the accumulation stage: upstream MS beat in, downstream SS result out.
interface sum_stage_if #(
  parameter int DWD     = 8,
  parameter int PSUMDWD = 16,
  parameter int PEROW   = 4
);
  typedef struct packed {
    logic       clr;
    logic       last;
    logic [3:0] zp;
    logic [3:0] shift;
  } ssctl_t;

  logic                                 MS_rdy;
  logic                                 MS_ack;
  logic [PEROW-1:0][PSUMDWD+DWD-1:0]    i_data;
  ssctl_t                               i_SSpipe_MS;
  logic                                 SS_rdy;
  logic                                 SS_ack;
  logic [PEROW-1:0][PSUMDWD-1:0]        o_data;
  logic [PEROW-1:0]                     o_sat;

  modport slave  (input  MS_rdy, i_data, i_SSpipe_MS, SS_ack,
                  output MS_ack, SS_rdy, o_data, o_sat);
  modport master (output MS_rdy, i_data, i_SSpipe_MS, SS_ack,
                  input  MS_ack, SS_rdy, o_data, o_sat);
endinterface

// File: rtl/sum_stage.sv
// PE-row accumulators with zero-point correction; last beat of a group emits a
// rounded, shifted, saturated psum into a single output slot (rdy/ack).
module sum_stage_row #(
  parameter int DWD     = 8,
  parameter int PSUMDWD = 16,
  parameter int ACCWD   = PSUMDWD + 6
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               xfer_i,
  input  logic               clr_i,
  input  logic               last_i,
  input  logic [3:0]         zp_i,
  input  logic [3:0]         shift_i,
  input  logic [PSUMDWD-1:0] psum_i,
  input  logic [DWD-1:0]     sum_i,
  output logic [PSUMDWD-1:0] psum_o,
  output logic               sat_o
);
  localparam logic [ACCWD-1:0]   AMAX = {1'b0, {(ACCWD-1){1'b1}}};
  localparam logic [ACCWD-1:0]   AMIN = {1'b1, {(ACCWD-1){1'b0}}};
  localparam logic [PSUMDWD-1:0] PMAX = {1'b0, {(PSUMDWD-1){1'b1}}};
  localparam logic [PSUMDWD-1:0] PMIN = {1'b1, {(PSUMDWD-1){1'b0}}};

  logic [ACCWD-1:0]         acc_q, acc_d;
  logic [PSUMDWD-1:0]       psum_q, psum_d;
  logic                     sat_q, sat_d;
  logic [ACCWD:0]           base, wide, rnd;
  logic [DWD+3:0]           prod;
  logic signed [ACCWD-1:0]  shifted;
  logic [ACCWD-PSUMDWD+1:0] hi;
  logic                     clamp1, clamp2, guard;

  always_comb begin
    base   = clr_i ? '0 : {acc_q[ACCWD-1], acc_q};
    prod   = {{DWD{1'b0}}, zp_i} * {4'b0, sum_i};
    // One guard bit above ACCWD so the clamp can see the true overflow direction
    wide   = base + {{(ACCWD+1-PSUMDWD){psum_i[PSUMDWD-1]}}, psum_i}
                  - {{(ACCWD+1-DWD-4){1'b0}}, prod};
    clamp1 = wide[ACCWD] != wide[ACCWD-1];
    acc_d  = clamp1 ? (wide[ACCWD] ? AMIN : AMAX) : wide[ACCWD-1:0];

    shifted = $signed(acc_d) >>> shift_i;
    guard   = (shift_i != 4'd0) ? acc_d[shift_i - 4'd1] : 1'b0;
    rnd     = {shifted[ACCWD-1], shifted} + {{ACCWD{1'b0}}, guard};
    hi      = rnd[ACCWD:PSUMDWD-1];
    clamp2  = !((&hi) || !(|hi));
    psum_d  = clamp2 ? (rnd[ACCWD] ? PMIN : PMAX) : rnd[PSUMDWD-1:0];
    sat_d   = clamp1 || clamp2;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      acc_q  <= '0;
      psum_q <= '0;
      sat_q  <= 1'b0;
    end else if (xfer_i) begin
      acc_q <= acc_d;
      if (last_i) begin
        psum_q <= psum_d;
        sat_q  <= sat_d;
      end
    end
  end

  assign psum_o = psum_q;
  assign sat_o  = sat_q;
endmodule

module sum_stage #(
  parameter int DWD     = 8,
  parameter int PSUMDWD = 16,
  parameter int PEROW   = 4,
  parameter int ACCWD   = PSUMDWD + 6
) (
  input  logic        i_clk,
  input  logic        i_rst,
  sum_stage_if.slave  bus
);
  logic ms_ack, xfer, emit;
  logic ss_rdy_q, ss_rdy_d;

  // A last beat only stalls while the slot is full and not draining this cycle
  assign ms_ack     = !(bus.i_SSpipe_MS.last && ss_rdy_q && !bus.SS_ack);
  assign xfer       = bus.MS_rdy && ms_ack;
  assign emit       = xfer && bus.i_SSpipe_MS.last;
  assign bus.MS_ack = ms_ack;
  assign bus.SS_rdy = ss_rdy_q;

  always_comb begin
    ss_rdy_d = ss_rdy_q;
    if (emit)                      ss_rdy_d = 1'b1;
    else if (ss_rdy_q && bus.SS_ack) ss_rdy_d = 1'b0;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) ss_rdy_q <= 1'b0;
    else       ss_rdy_q <= ss_rdy_d;
  end

  for (genvar r = 0; r < PEROW; r++) begin : g_row
    sum_stage_row #(.DWD(DWD), .PSUMDWD(PSUMDWD), .ACCWD(ACCWD)) u_row (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .xfer_i  (xfer),
      .clr_i   (bus.i_SSpipe_MS.clr),
      .last_i  (bus.i_SSpipe_MS.last),
      .zp_i    (bus.i_SSpipe_MS.zp),
      .shift_i (bus.i_SSpipe_MS.shift),
      .psum_i  (bus.i_data[r][PSUMDWD+DWD-1:DWD]),
      .sum_i   (bus.i_data[r][DWD-1:0]),
      .psum_o  (bus.o_data[r]),
      .sat_o   (bus.o_sat[r])
    );
  end
endmodule

// File: tb/tb_sum_stage.sv
// Bench for sum_stage: reference-model scoreboard on every output handshake,
// plus fixed-value checks for the documented corner cases.
module tb_sum_stage;
  localparam int DWD = 8, PSUMDWD = 16, PEROW = 4, ACCWD = PSUMDWD + 6;
  localparam longint AMAX = (64'sd1 <<< (ACCWD-1)) - 1;
  localparam longint AMIN = -(64'sd1 <<< (ACCWD-1));

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sum_stage_if #(.DWD(DWD), .PSUMDWD(PSUMDWD), .PEROW(PEROW)) bus ();
  sum_stage #(.DWD(DWD), .PSUMDWD(PSUMDWD), .PEROW(PEROW), .ACCWD(ACCWD)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  typedef struct {
    logic [PEROW-1:0][PSUMDWD-1:0] d;
    logic [PEROW-1:0]              s;
  } exp_t;

  typedef struct {
    bit clr, last;
    int zp, sh, ps, sm, exp_d;
    bit exp_s;
  } vec_t;

  exp_t   sb[$];
  longint macc [PEROW];
  int     n_chk = 0, n_fail = 0;
  vec_t   tbl [8];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(string name, longint act, longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_out(string name, int v, bit s);
    logic [PEROW-1:0][PSUMDWD-1:0] ed;
    for (int r = 0; r < PEROW; r++) ed[r] = 16'(v);
    n_chk++;
    if (bus.o_data !== ed || bus.o_sat !== {PEROW{s}} || bus.SS_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s: got data=%h sat=%b rdy=%b, expected data=%h sat=%b rdy=1",
               name, bus.o_data, bus.o_sat, bus.SS_rdy, ed, {PEROW{s}});
    end
  endtask

  task automatic drive(bit rdy, bit clr, bit last, int zp, int sh, int ps, int sm);
    bus.MS_rdy            = rdy;
    bus.i_SSpipe_MS.clr   = clr;
    bus.i_SSpipe_MS.last  = last;
    bus.i_SSpipe_MS.zp    = 4'(zp);
    bus.i_SSpipe_MS.shift = 4'(sh);
    for (int r = 0; r < PEROW; r++) bus.i_data[r] = {16'(ps), 8'(sm)};
  endtask

  // Reference model: plain integer arithmetic on the beat that just transferred
  task automatic mdl_beat();
    exp_t   e;
    longint v, rnd;
    int     ps, sm, zp, sh;
    bit     s1, s2;
    zp = int'(bus.i_SSpipe_MS.zp);
    sh = int'(bus.i_SSpipe_MS.shift);
    for (int r = 0; r < PEROW; r++) begin
      ps = int'($signed(bus.i_data[r][PSUMDWD+DWD-1:DWD]));
      sm = int'(bus.i_data[r][DWD-1:0]);
      v  = (bus.i_SSpipe_MS.clr ? 0 : macc[r]) + ps - zp * sm;
      s1 = (v > AMAX) || (v < AMIN);
      if (v > AMAX) v = AMAX;
      if (v < AMIN) v = AMIN;
      macc[r] = v;
      rnd = (v >>> sh) + ((sh != 0) ? ((v >>> (sh - 1)) & 1) : 0);
      s2  = (rnd > 32767) || (rnd < -32768);
      if (rnd > 32767)  rnd = 32767;
      if (rnd < -32768) rnd = -32768;
      e.d[r] = 16'(rnd);
      e.s[r] = s1 || s2;
    end
    if (bus.i_SSpipe_MS.last) sb.push_back(e);
  endtask

  // One clock: compare any completing output handshake, then advance the model
  task automatic tick();
    bit   x, p;
    exp_t e;
    #2;
    x = bus.MS_rdy && bus.MS_ack;
    p = bus.SS_rdy && bus.SS_ack;
    if (p) begin
      n_chk++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_underflow: got output %h, expected none", bus.o_data);
      end else begin
        e = sb.pop_front();
        if (bus.o_data !== e.d || bus.o_sat !== e.s) begin
          n_fail++;
          $display("FAIL sb_out: got data=%h sat=%b, expected data=%h sat=%b",
                   bus.o_data, bus.o_sat, e.d, e.s);
        end
      end
    end
    @(posedge clk);
    if (x) mdl_beat();
    #1;
  endtask

  initial begin
    tbl[0] = '{1, 1, 2, 0, 100,    10,  80,     0};
    tbl[1] = '{1, 1, 0, 1, 7,      0,   4,      0};
    tbl[2] = '{1, 1, 0, 2, -5,     0,   -1,     0};
    tbl[3] = '{1, 1, 15, 0, 0,     255, -3825,  0};
    tbl[4] = '{1, 1, 0, 0, 32767,  0,   32767,  0};
    tbl[5] = '{1, 1, 1, 0, -32768, 1,   -32768, 1};
    tbl[6] = '{1, 1, 0, 4, -32768, 0,   -2048,  0};
    tbl[7] = '{1, 1, 3, 3, 1000,   20,  118,    0};
    for (int r = 0; r < PEROW; r++) macc[r] = 0;

    drive(0, 0, 0, 0, 0, 0, 0);
    bus.SS_ack = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ss_rdy", bus.SS_rdy, 0);
    chk("rst_o_data", bus.o_data, 0);
    chk("rst_o_sat",  bus.o_sat,  0);
    chk("rst_ms_ack", bus.MS_ack, 1);
    rst = 1'b0;
    tick();

    // single-beat group
    drive(1, 1, 1, 2, 0, 100, 10); tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    chk_out("single_beat", 80, 0);
    tick();

    // three-beat accumulate with rounding
    drive(1, 1, 0, 0, 1, 5, 0); tick();
    drive(1, 0, 0, 0, 1, 6, 0); tick();
    drive(1, 0, 1, 0, 1, 7, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    chk_out("acc3_sum18", 9, 0);
    drive(1, 1, 0, 0, 1, 5, 0); tick();
    drive(1, 0, 0, 0, 1, 6, 0); tick();
    drive(1, 0, 1, 0, 1, 8, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    chk_out("acc3_sum19", 10, 0);

    // saturation, positive then negative
    for (int i = 0; i < 70; i++) begin
      drive(1, i == 0, i == 69, 0, 0, 32767, 0); tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    chk_out("sat_pos", 32767, 1);
    for (int i = 0; i < 2; i++) begin
      drive(1, i == 0, i == 1, 0, 0, -32768, 0); tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    chk_out("sat_neg", -32768, 1);
    tick();

    // backpressure
    drive(1, 1, 1, 0, 0, 11, 0); tick();
    bus.SS_ack = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0); tick();
    chk_out("bp_hold", 11, 0);
    drive(1, 1, 1, 0, 0, 22, 0); #1;
    chk("bp_last_stall", bus.MS_ack, 0);
    tick();
    chk_out("bp_stable", 11, 0);
    drive(1, 1, 0, 0, 0, 4, 0); #1;
    chk("bp_nonlast_ack", bus.MS_ack, 1);
    tick();
    drive(1, 0, 1, 0, 0, 5, 0); #1;
    chk("bp_last_stall2", bus.MS_ack, 0);
    tick();
    bus.SS_ack = 1'b1; #1;
    chk("bp_release_ack", bus.MS_ack, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    chk_out("bp_new_result", 9, 0);
    tick();

    // back-to-back single-beat groups from the vector table
    for (int i = 0; i < 8; i++) begin
      drive(1, tbl[i].clr, tbl[i].last, tbl[i].zp, tbl[i].sh, tbl[i].ps, tbl[i].sm);
      tick();
      chk_out($sformatf("b2b_%0d", i), tbl[i].exp_d, tbl[i].exp_s);
    end
    drive(0, 0, 0, 0, 0, 0, 0); tick();

    // mid-operation reset with an output pending
    drive(1, 1, 1, 0, 0, 50, 0); tick();
    bus.SS_ack = 1'b0;
    drive(1, 1, 0, 0, 0, 7, 0); tick();
    drive(1, 0, 0, 0, 0, 7, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1; #1;
    chk("mrst_ss_rdy", bus.SS_rdy, 0);
    chk("mrst_o_data", bus.o_data, 0);
    sb.delete();
    for (int r = 0; r < PEROW; r++) macc[r] = 0;
    #2 rst = 1'b0;
    tick();
    bus.SS_ack = 1'b1;
    drive(1, 0, 1, 0, 0, 3, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    chk_out("mrst_first_beat", 3, 0);
    tick();

    // randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      bus.MS_rdy            = ($urandom_range(3) != 0);
      bus.SS_ack            = ($urandom_range(2) != 0);
      bus.i_SSpipe_MS.clr   = ($urandom_range(3) == 0);
      bus.i_SSpipe_MS.last  = ($urandom_range(2) == 0);
      bus.i_SSpipe_MS.zp    = 4'($urandom);
      bus.i_SSpipe_MS.shift = 4'($urandom);
      for (int r = 0; r < PEROW; r++) bus.i_data[r] = 24'($urandom);
      tick();
    end

    drive(0, 0, 0, 0, 0, 0, 0);
    bus.SS_ack = 1'b1;
    repeat (2) tick();
    chk("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
